isp_loader: RTL and testbench

Writer side of the instruction RAM's in-system-programming port. Consumes a byte stream (typically from the UART receiver) carrying a framed program image, assembles bytes into 32-bit little-endian instruction words, and drives `wen`/`din`/`addr` into the instruction RAM's B port. Holds the core in reset (`core_hold`) while a frame is being loaded, then reports done or error.

---
 rtl/isp_loader_pkg.sv | 32 +++
 rtl/isp_loader_if.sv | 27 ++
 rtl/isp_loader.sv | 157 +++++++++++++++
 tb/tb_isp_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/isp_loader_pkg.sv
// Shared types and helpers for the instruction-RAM in-system-programming loader.
package isp_loader_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [7:0]  HDR_BYTE = 8'hA5;

  typedef logic [INST_W-1:0] inst_bus_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  // Same address-width rule as the instruction RAM: bits needed to hold depth.
  function automatic int unsigned clogb2(input int unsigned depth);
    int unsigned d;
    int unsigned n;
    d = depth;
    n = 0;
    while (d > 0) begin
      d = d >> 1;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/isp_loader_if.sv
// Byte-stream input and instruction-RAM write port of the ISP loader.
interface isp_loader_if
  import isp_loader_pkg::*;
#(
  parameter int unsigned AW = 16
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          clr;
  logic          wen;
  inst_bus_t     din;
  logic [AW-1:0] addr;
  logic          core_hold;
  logic          done;
  logic          err;

  modport slave (
    input  rx_valid, rx_data, clr,
    output rx_ready, wen, din, addr, core_hold, done, err
  );

  modport master (
    output rx_valid, rx_data, clr,
    input  rx_ready, wen, din, addr, core_hold, done, err
  );
endinterface

// File: rtl/isp_loader.sv
// Frames a byte stream into 32-bit little-endian words and writes them into
// the instruction RAM, holding the core in reset while a frame is loading.
module isp_loader
  import isp_loader_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = 65536,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  isp_loader_if.slave  bus
);

  localparam int unsigned AW = clogb2(RAM_DEPTH - 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   idx_q, idx_d;
  logic [1:0]    lane_q, lane_d;
  logic [23:0]   word_q, word_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          wen_q, wen_d;
  inst_bus_t     din_q, din_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rx_ready_q, rx_ready_d;
  logic          core_hold_q, core_hold_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          acc;
  logic          active;
  logic          tmo;
  logic [15:0]   n_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      lane_q      <= '0;
      word_q      <= '0;
      sum_q       <= '0;
      tcnt_q      <= '0;
      wen_q       <= 1'b0;
      din_q       <= '0;
      addr_q      <= '0;
      rx_ready_q  <= 1'b1;
      core_hold_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      sum_q       <= sum_d;
      tcnt_q      <= tcnt_d;
      wen_q       <= wen_d;
      din_q       <= din_d;
      addr_q      <= addr_d;
      rx_ready_q  <= rx_ready_d;
      core_hold_q <= core_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    word_d  = word_q;
    sum_d   = sum_q;
    tcnt_d  = '0;
    wen_d   = 1'b0;
    din_d   = din_q;
    addr_d  = addr_q;

    acc    = bus.rx_valid && rx_ready_q;
    n_len  = {bus.rx_data, len_q[7:0]};
    active = (state_q == S_LEN0) || (state_q == S_LEN1) ||
             (state_q == S_DATA) || (state_q == S_CSUM);
    tmo    = (tcnt_q == TW'(TIMEOUT));

    // Inter-byte watchdog only runs while a frame is in flight.
    if (active && !acc) tcnt_d = tcnt_q + TW'(1);

    case (state_q)
      S_IDLE: begin
        if (acc && (bus.rx_data == HDR_BYTE)) state_d = S_LEN0;
      end
      S_LEN0: begin
        if (acc) begin
          len_d[7:0] = bus.rx_data;
          state_d    = S_LEN1;
        end else if (tmo) begin
          state_d = S_ERR;
        end
      end
      S_LEN1: begin
        if (acc) begin
          len_d  = n_len;
          idx_d  = '0;
          lane_d = '0;
          sum_d  = '0;
          if (n_len == 16'd0)                 state_d = S_CSUM;
          else if (32'(n_len) > RAM_DEPTH)    state_d = S_ERR;
          else                                state_d = S_DATA;
        end else if (tmo) begin
          state_d = S_ERR;
        end
      end
      S_DATA: begin
        if (acc) begin
          sum_d  = sum_q + bus.rx_data;
          word_d = {bus.rx_data, word_q[23:8]};
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            wen_d  = 1'b1;
            din_d  = {bus.rx_data, word_q};
            addr_d = AW'(idx_q);
            idx_d  = idx_q + 16'd1;
            if (idx_q == (len_q - 16'd1)) state_d = S_CSUM;
          end
        end else if (tmo) begin
          state_d = S_ERR;
        end
      end
      S_CSUM: begin
        if (acc) state_d = (bus.rx_data == sum_q) ? S_DONE : S_ERR;
        else if (tmo) state_d = S_ERR;
      end
      S_DONE, S_ERR: begin
        if (bus.clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d  = (state_d != S_DONE) && (state_d != S_ERR);
    core_hold_d = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.wen       = wen_q;
  assign bus.din       = din_q;
  assign bus.addr      = addr_q;
  assign bus.core_hold = core_hold_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_isp_loader.sv
// Directed bench for isp_loader: frames driven byte by byte, RAM writes
// checked against a queue of expected (addr, data) pairs.
module tb_isp_loader;
  import isp_loader_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO   = 40;
  localparam int unsigned AW    = clogb2(DEPTH - 1);

  logic clk;
  logic rst;

  isp_loader_if #(.AW(AW)) bus ();

  isp_loader #(.RAM_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] fb[$];
  int         vectors = 0;
  int         miscmp  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wen_unexpected", {31'd0, bus.wen}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.addr), e.addr);
        chk("wr_din", bus.din, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("rx_ready_wait", {31'd0, bus.rx_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic send_fb();
    while (fb.size() > 0) send_byte(fb.pop_front());
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic chk_status(input string tag, input logic done, input logic err, input logic hold);
    chk({tag, "_done"}, {31'd0, bus.done}, {31'd0, done});
    chk({tag, "_err"},  {31'd0, bus.err},  {31'd0, err});
    chk({tag, "_hold"}, {31'd0, bus.core_hold}, {31'd0, hold});
  endtask

  task automatic push_two_word_frame(input logic [7:0] csum);
    fb = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h6F, 8'h00, 8'h00, 8'h00, csum};
    push_wr(32'd0, 32'h0000_0013);
    push_wr(32'd1, 32'h0000_006F);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  s;

    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.clr      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values
    chk("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    chk("rst_wen", {31'd0, bus.wen}, 32'd0);
    chk("rst_din", bus.din, 32'd0);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk_status("rst", 1'b0, 1'b0, 1'b0);

    // Good two-word frame, back-to-back bytes
    push_two_word_frame(8'h82);
    send_fb();
    idle(2);
    chk_status("good", 1'b1, 1'b0, 1'b1);
    chk("good_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    chk("good_sb_left", 32'(exp_q.size()), 32'd0);
    pulse_clr();
    chk_status("good_clr", 1'b0, 1'b0, 1'b0);
    chk("good_clr_rdy", {31'd0, bus.rx_ready}, 32'd1);

    // Bad checksum: writes still land, then error
    push_two_word_frame(8'h83);
    send_fb();
    idle(2);
    chk_status("badsum", 1'b0, 1'b1, 1'b1);
    chk("badsum_sb_left", 32'(exp_q.size()), 32'd0);
    pulse_clr();
    chk_status("badsum_clr", 1'b0, 1'b0, 1'b0);

    // Garbage before header is dropped; clr outside DONE/ERR is ignored
    fb = '{8'h00, 8'hFF, 8'h5A};
    send_fb();
    idle(2);
    chk_status("garbage", 1'b0, 1'b0, 1'b0);
    push_two_word_frame(8'h82);
    send_byte(fb.pop_front());
    send_byte(fb.pop_front());
    idle(1);
    pulse_clr();
    chk_status("clr_ignored", 1'b0, 1'b0, 1'b1);
    send_fb();
    idle(2);
    chk_status("garbage_frame", 1'b1, 1'b0, 1'b1);
    chk("garbage_sb_left", 32'(exp_q.size()), 32'd0);
    pulse_clr();

    // Length one beyond RAM depth: immediate error, no writes
    fb = '{8'hA5, 8'(DEPTH + 1), 8'h00};
    send_fb();
    idle(1);
    chk_status("overlen", 1'b0, 1'b1, 1'b1);
    chk("overlen_rdy", {31'd0, bus.rx_ready}, 32'd0);
    pulse_clr();

    // Length exactly RAM depth: last word lands at the top address
    fb = '{8'hA5, 8'(DEPTH), 8'h00};
    s = 8'h00;
    for (int k = 0; k < int'(DEPTH); k++) begin
      w = $urandom;
      push_wr(32'(k), w);
      for (int b = 0; b < 4; b++) begin
        fb.push_back(w[8*b +: 8]);
        s = s + w[8*b +: 8];
      end
    end
    fb.push_back(s);
    send_fb();
    idle(2);
    chk_status("full", 1'b1, 1'b0, 1'b1);
    chk("full_last_addr", 32'(bus.addr), DEPTH - 1);
    chk("full_sb_left", 32'(exp_q.size()), 32'd0);
    pulse_clr();

    // Zero-length frame: checksum of nothing is 0
    fb = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_fb();
    idle(2);
    chk_status("zero", 1'b1, 1'b0, 1'b1);
    pulse_clr();

    // Stall after second data byte
    fb = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    send_fb();
    idle(TMO / 2);
    chk_status("stall_early", 1'b0, 1'b0, 1'b1);
    idle(TMO);
    chk_status("stall_tmo", 1'b0, 1'b1, 1'b1);
    pulse_clr();
    chk_status("stall_clr", 1'b0, 1'b0, 1'b0);

    // Reset mid-word, then a fresh one-word frame
    fb = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    send_fb();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_status("midrst", 1'b0, 1'b0, 1'b0);
    chk("midrst_wen", {31'd0, bus.wen}, 32'd0);
    fb = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
    push_wr(32'd0, 32'hEFBE_ADDE);
    send_fb();
    idle(2);
    chk_status("post_rst", 1'b1, 1'b0, 1'b1);
    chk("post_rst_sb_left", 32'(exp_q.size()), 32'd0);
    pulse_clr();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule
